lsu_initiator: RTL and testbench
================================

Name: lsu_initiator

Overview:
- Load/store initiator in the MEM stage. It is the requesting end of the data-memory interface.
- It turns the MemRead/MemWrite/Funct3 commands and the byte address into a handshaked word-bus transaction with byte enables and lane-replicated write data.
- It extracts and sign/zero-extends load data, and stalls the pipeline until the access completes.
- It flags misaligned accesses, illegal commands, and bus timeouts.

Parameters:
- DM_ADDRESS, 9, word-address width on the memory bus.
- DATA_W, 32, data width. Only 32 is supported; 4 byte lanes.
- TIMEOUT_CYC, 255, maximum cycles spent waiting for mem_gnt or mem_rvalid before a fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load command from control unit.
- MemWrite  in  1  store command from control unit.
- Funct3  in  3  instruction bits 14:12.
- addr  in  32  byte address (ALU result).
- wd  in  DATA_W  store data (rs2).
- rd  out  DATA_W  extended load result.
- stall  out  1  hold pipeline.
- fault  out  1  one-cycle pulse: misaligned, illegal, or timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  DM_ADDRESS  word address = addr[DM_ADDRESS+1:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rd=0, fault=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0. Because the reset is asynchronous, mem_req drops immediately even mid-transaction.
- Legal Funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal Funct3 for stores: 000 SB, 001 SH, 010 SW.
- Any other Funct3 is illegal. MemRead=MemWrite=1 is also illegal.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- Store byte enables: SB be=0001<<addr[1:0]; SH be=0011<<addr[1:0]; SW be=1111.
- Store write data: SB wdata={4{wd[7:0]}}; SH wdata={2{wd[15:0]}}; SW wdata=wd.
- Load extraction: lane = mem_rdata >> (8*addr[1:0]). Byte or half is taken from the lane; LB/LH sign-extend, LBU/LHU zero-extend.
- Load byte enables for reads are the same pattern as stores. The memory may ignore them.

State machine (IDLE, REQ, WAIT, DONE):
- IDLE:
  - No command: stall=0.
  - Illegal or misaligned command: fault=1 for that cycle, stall=0, no bus activity, rd unchanged. The pipeline proceeds.
  - Legal command: stall=1 combinationally. Register mem_addr, mem_be, mem_we, mem_wdata, plus Funct3 and addr[1:0] internally. Next state REQ.
- REQ:
  - mem_req=1, stall=1. Request fields are held stable until mem_gnt.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT. mem_req deasserts next cycle.
  - If mem_gnt and mem_rvalid arrive in the same cycle for a load, data is captured and the next state is DONE.
- WAIT:
  - stall=1. On mem_rvalid, capture the extracted result into rd and go to DONE.
- DONE:
  - stall=0 for exactly one cycle. rd is valid; the pipeline advances at the end of this cycle. Next state IDLE.
- Minimum latency:
  - Store with mem_gnt in the first REQ cycle: stall high 2 cycles (IDLE, REQ).
  - Load with same-cycle gnt and rvalid: stall high 2 cycles.
- Timeout:
  - The counter clears on entering REQ and on leaving WAIT. It increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYC: fault=1, rd=0, mem_req=0, next state DONE.
- Stray signals: mem_rvalid outside REQ/WAIT is ignored, as is mem_gnt outside REQ.
- Inputs must be held stable by the pipeline while stall=1. They are sampled only at IDLE acceptance.
- rd holds its last value outside DONE.

Decomposition:
- Package lsu_pkg holds:
  - Funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - Type be_t = logic[3:0].
- One combinational sub-module, lsu_align. Inputs: Funct3, addr[1:0], wd, mem_rdata. Outputs: be, wdata, load result, misaligned, illegal. The FSM, registers and timeout stay in lsu_initiator.

Test Plan:
- SW addr=0x10, wd=0xDEADBEEF, gnt on the 2nd REQ cycle -> mem_addr=4, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1; stall high 3 cycles then low 1 cycle (DONE).
- SB addr=0x13, wd=0x000000A5 -> mem_addr=4, mem_be=1000, mem_wdata=0xA5A5A5A5. Then SH addr=0x12, wd=0x1234 -> mem_be=1100, mem_wdata=0x12341234.
- LB addr=0x12, mem_rdata=0x1280_3456 with gnt and rvalid in the same cycle -> rd=0xFFFFFF80 in DONE. Repeat with LBU -> 0x00000080; LHU addr=0x12 -> 0x00001280.
- LH addr=0x11 -> fault pulse 1 cycle, mem_req never asserts, stall=0, rd unchanged. Also Funct3=011 with MemRead -> fault, and MemRead=MemWrite=1 -> fault.
- LW addr=0x8 with gnt but no rvalid for TIMEOUT_CYC=255 cycles -> fault=1, rd=0, DONE, then IDLE; a later rvalid is ignored.
- rst_n=0 asynchronously while in WAIT -> mem_req=0, stall=0, fault=0, rd=0 immediately. After release, the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and byte-enable type for the load/store initiator
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  typedef logic [3:0] be_t;
endpackage

// File: rtl/lsu_initiator_if.sv
// lsu_initiator_if: word-wide data-memory request/response bus
// master drives mem_req/mem_we/mem_addr/mem_be/mem_wdata; slave drives mem_gnt/mem_rvalid/mem_rdata
interface lsu_initiator_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  import lsu_pkg::*;
  logic                  mem_req;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  be_t                   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering -- store enables/data replication, load extraction, command checks
// in: i_funct3, i_off (addr[1:0]), i_store, i_wd, i_rdata; out: o_be, o_wdata, o_rd, o_misaligned, o_illegal
module lsu_align import lsu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  input  logic              i_store,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [DATA_W-1:0] i_rdata,
  output be_t               o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rd,
  output logic              o_misaligned,
  output logic              o_illegal
);
  logic [1:0]        w_sz;
  logic [DATA_W-1:0] w_lane;
  assign w_sz   = i_funct3[1:0];
  assign w_lane = i_rdata >> {i_off, 3'b000};
  always_comb begin
    o_be = w_sz == 2'd0 ? be_t'(4'b0001 << i_off) : w_sz == 2'd1 ? be_t'(4'b0011 << i_off) : 4'b1111;
    o_wdata = w_sz == 2'd0 ? {4{i_wd[7:0]}} : w_sz == 2'd1 ? {2{i_wd[15:0]}} : i_wd;
    o_rd = i_funct3 == F3_B  ? {{24{w_lane[7]}}, w_lane[7:0]} :
           i_funct3 == F3_H  ? {{16{w_lane[15]}}, w_lane[15:0]} :
           i_funct3 == F3_BU ? {24'b0, w_lane[7:0]} :
           i_funct3 == F3_HU ? {16'b0, w_lane[15:0]} : w_lane;
    o_misaligned = (w_sz == 2'd1 && i_off[0]) || (w_sz == 2'd2 && i_off != 2'd0);
    o_illegal = i_store ? i_funct3 > F3_W : !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end
endmodule

// File: rtl/lsu_initiator.sv
// lsu_initiator: MEM-stage load/store initiator driving a handshaked word bus and stalling the pipeline
// in: clk, rst_n, MemRead, MemWrite, Funct3, addr, wd; out: rd, stall, fault; bus: lsu_initiator_if.master
module lsu_initiator import lsu_pkg::*; #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              stall,
  output logic              fault,
  lsu_initiator_if.master   bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  lsu_state_t            r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  be_t                   r_be;
  logic [DATA_W-1:0]     r_wdata, r_rd;
  logic                  w_idle, w_busy, w_cmd, w_bad, w_go, w_to, w_cap, w_misaligned, w_illegal, w_unused;
  be_t                   w_be;
  logic [DATA_W-1:0]     w_wdata, w_ld;
  assign w_unused = ^addr[31:DM_ADDRESS+2];
  assign w_idle   = r_state == IDLE;
  assign w_busy   = r_state == REQ || r_state == WAIT;
  assign w_cmd    = MemRead | MemWrite;
  assign w_bad    = (MemRead & MemWrite) | w_illegal | w_misaligned;
  assign w_go     = w_idle & w_cmd & ~w_bad;
  // timeout wins over a response arriving in the same cycle
  assign w_to     = w_busy && r_cnt == CW'(TIMEOUT_CYC);
  assign w_cap    = ~w_to & ~r_we & bus.mem_rvalid & (r_state == WAIT | (r_state == REQ & bus.mem_gnt));
  // live command is decoded in IDLE; the latched one drives load extraction afterwards
  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_funct3     (w_idle ? Funct3 : r_f3),
    .i_off        (w_idle ? addr[1:0] : r_off),
    .i_store      (w_idle ? MemWrite : r_we),
    .i_wd         (wd),
    .i_rdata      (bus.mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rd         (w_ld),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_go ? REQ : IDLE;
      REQ:     w_next = w_to ? DONE : !bus.mem_gnt ? REQ : (r_we || bus.mem_rvalid) ? DONE : WAIT;
      WAIT:    w_next = (w_to || bus.mem_rvalid) ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // gated by rst_n so the pipeline sees a quiet interface while reset is held
  always_comb begin
    stall         = rst_n & (w_go | w_busy);
    fault         = rst_n & ((w_idle & w_cmd & w_bad) | w_to);
    bus.mem_req   = r_state == REQ & ~w_to;
    bus.mem_we    = r_we;
    bus.mem_addr  = r_addr;
    bus.mem_be    = r_be;
    bus.mem_wdata = r_wdata;
    rd            = r_rd;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_f3    <= '0;
      r_off   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_go) begin
        r_f3    <= Funct3;
        r_off   <= addr[1:0];
        r_we    <= MemWrite;
        r_addr  <= addr[DM_ADDRESS+1:2];
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
      if (w_to) r_rd <= '0;
      else if (w_cap) r_rd <= w_ld;
      r_cnt <= w_busy && (w_next == REQ || w_next == WAIT) ? r_cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_lsu_initiator.sv
// tb_lsu_initiator: randomized lockstep check of lsu_initiator against a transaction-level model
module tb_lsu_initiator;
  localparam int TO = 255;
  logic        clk, rst_n, MemRead, MemWrite, stall, fault;
  logic [2:0]  Funct3;
  logic [31:0] addr, wd, rd, m_rd;
  int          total, bad;
  lsu_initiator_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();
  lsu_initiator #(.DM_ADDRESS(9), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .addr(addr), .wd(wd), .rd(rd), .stall(stall), .fault(fault), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end act=running exp=finished");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, want);
    end
  endtask
  function automatic bit m_bad(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (mr && mw) return 1'b1;
    if (mw ? f3 > 3'd2 : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz, off;
    logic [3:0] b;
    sz = 1 << f3[1:0];
    off = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = i >= off && i < off + sz;
    return b;
  endfunction
  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] w);
    int sz;
    logic [31:0] o;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) o[8*i+:8] = w[8*(i%sz)+:8];
    return o;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
    int sz;
    longint v;
    sz = 1 << f3[1:0];
    v = longint'(rdat >> (8 * (a % 4)));
    if (sz < 4) v = v % (longint'(1) << (8 * sz));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction
  // g: REQ cycle (from 0) carrying mem_gnt; r: cycles from gnt to rvalid; called and returns at posedge+1 in IDLE
  task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input int g, input int r, input logic [31:0] rdat);
    int kc, last;
    bit to;
    MemRead = mr; MemWrite = mw; Funct3 = f3; addr = a; wd = w;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = rdat;
    @(negedge clk);
    if (m_bad(mr, mw, f3, a)) begin
      chk("flt_pulse", fault, 1);
      chk("flt_stall", stall, 0);
      chk("flt_req", bus.mem_req, 0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      chk("flt_clear", fault, 0);
      chk("flt_req2", bus.mem_req, 0);
      chk("flt_rd", rd, m_rd);
      @(posedge clk); #1;
      return;
    end
    chk("acc_stall", stall, 1);
    chk("acc_fault", fault, 0);
    chk("acc_req", bus.mem_req, 0);
    kc = mw ? g : g + r;
    to = kc >= TO;
    last = to ? TO : kc;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      bus.mem_gnt = k == g;
      bus.mem_rvalid = mr && k == g + r;
      @(negedge clk);
      chk("b_stall", stall, 1);
      chk("b_req", bus.mem_req, k <= g && k != TO);
      chk("b_fault", fault, to && k == TO);
      if (k <= g && k != TO) begin
        chk("b_addr", 32'(bus.mem_addr), (a >> 2) % 512);
        chk("b_be", bus.mem_be, m_be(f3, a));
        chk("b_we", bus.mem_we, mw);
        if (mw) chk("b_wdata", bus.mem_wdata, m_wd(f3, w));
      end
    end
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'($urandom_range(0, 1));
    MemRead = 1'b0; MemWrite = 1'b0;
    if (to) m_rd = 32'h0;
    else if (mr) m_rd = m_load(f3, a, rdat);
    @(negedge clk);
    chk("d_stall", stall, 0);
    chk("d_fault", fault, 0);
    chk("d_req", bus.mem_req, 0);
    chk("d_rd", rd, m_rd);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
  endtask
  task automatic idle_stray();
    MemRead = 1'b0; MemWrite = 1'b0;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("s_stall", stall, 0);
    chk("s_req", bus.mem_req, 0);
    chk("s_fault", fault, 0);
    chk("s_rd", rd, m_rd);
    @(posedge clk); #1;
  endtask
  task automatic rst_mid(input int g);
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; addr = 32'h8; wd = 32'h0;
    bus.mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.mem_gnt = g == 0;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    chk("rm_stall", stall, 1);
    chk("rm_req", bus.mem_req, g > 0);
    #2 rst_n = 1'b0;
    #1;
    m_rd = 32'h0;
    chk("rm_req0", bus.mem_req, 0);
    chk("rm_stall0", stall, 0);
    chk("rm_fault0", fault, 0);
    chk("rm_rd0", rd, m_rd);
    MemRead = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    total = 0; bad = 0; m_rd = 32'h0;
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0; addr = 32'h0; wd = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("r_rd", rd, 0);
    chk("r_stall", stall, 0);
    chk("r_fault", fault, 0);
    chk("r_req", bus.mem_req, 0);
    chk("r_we", bus.mem_we, 0);
    chk("r_be", bus.mem_be, 0);
    chk("r_addr", 32'(bus.mem_addr), 0);
    chk("r_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0);
    run_op(0, 1, 3'b000, 32'h13, 32'h000000A5, 0, 0, 32'h0);
    run_op(0, 1, 3'b001, 32'h12, 32'h00001234, 0, 0, 32'h0);
    run_op(1, 0, 3'b000, 32'h12, 32'h0, 0, 0, 32'h12803456);
    run_op(1, 0, 3'b100, 32'h12, 32'h0, 0, 0, 32'h12803456);
    run_op(1, 0, 3'b101, 32'h12, 32'h0, 0, 0, 32'h12803456);
    run_op(1, 0, 3'b001, 32'h11, 32'h0, 0, 0, 32'h0);
    run_op(1, 0, 3'b011, 32'h10, 32'h0, 0, 0, 32'h0);
    run_op(1, 1, 3'b010, 32'h10, 32'h0, 0, 0, 32'h0);
    run_op(1, 0, 3'b010, 32'h8, 32'h0, 0, 1000, 32'hCAFEF00D);
    idle_stray();
    run_op(0, 1, 3'b010, 32'h20, 32'h01234567, 1000, 0, 32'h0);
    run_op(1, 0, 3'b010, 32'h8, 32'h0, 1, 2, 32'h87654321);
    rst_mid(0);
    run_op(1, 0, 3'b010, 32'h8, 32'h0, 0, 1, 32'h13579BDF);
    rst_mid(2);
    run_op(1, 0, 3'b010, 32'h8, 32'h0, 2, 0, 32'h2468ACE0);
    for (int n = 0; n < 300; n++) begin
      int c, sz;
      logic [2:0] f;
      logic [31:0] a;
      c = int'($urandom_range(0, 9));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      sz = 1 << f[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      run_op(c <= 5, c == 0 || c >= 6, f, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      if (n % 25 == 0) idle_stray();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
